// File: rtl/ps2_key_event_rx.sv
// ps2_key_event_rx
// PS/2 keyboard receiver. It synchronises the raw PS/2 clock and data lines and
// checks each 11-bit frame (start, 8 data bits, odd parity, stop, inter-bit
// timeout). Valid bytes pass through an E0/F0/E1 prefix decoder, and the
// resulting {ext, brk, code} key events are buffered in a first-word-fall-through
// FIFO with a valid/ready interface.
module ps2_key_event_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 8,
    localparam int LW            = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic          key_clk,
    input  logic          key_data,
    output logic          ev_valid,
    input  logic          ev_ready,
    output logic [7:0]    ev_code,
    output logic          ev_ext,
    output logic          ev_brk,
    output logic [LW-1:0] fifo_level,
    output logic          frame_err,
    output logic          overflow,
    input  logic          clr_ovf
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} frame_state_t;

    // synchroniser and edge detect state
    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    logic                   clk_s, data_s, fall;

    // frame receiver state
    frame_state_t state_q, state_d;
    logic [2:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]   shift_q, shift_d;
    logic         parity_q, parity_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [7:0]   byte_q, byte_d;
    logic         byte_ok_q, byte_ok_d;
    logic         bad_frame_q, bad_frame_d;
    logic         frame_err_q, frame_err_d;
    logic         timeout_hit;

    // prefix decoder state
    logic         ext_q, ext_d, brk_q, brk_d;
    logic [2:0]   skip_q, skip_d;
    logic         push;
    logic [9:0]   push_data;

    // event FIFO state
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] count_q, count_d;
    logic [9:0]    head_q, head_d;
    logic          overflow_q, overflow_d;
    logic          full, pop, do_push;

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];
    assign fall   = clk_prev_q & ~clk_s;

    // shift the raw lines through the synchroniser and remember the previous clock level
    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], key_clk};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], key_data};
        clk_prev_d  = clk_s;
    end

    // frame FSM: advances on each PS/2 falling edge, aborts on inter-bit timeout
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        tcnt_d      = tcnt_q;
        byte_d      = byte_q;
        byte_ok_d   = 1'b0;
        bad_frame_d = 1'b0;
        timeout_hit = 1'b0;
        if (fall) begin
            tcnt_d = '0;
            unique case (state_q)
                S_IDLE: begin
                    if (!data_s) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end
                end
                S_DATA: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    parity_d = data_s;
                    state_d  = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if ((^{shift_q, parity_q}) && data_s) begin
                        byte_ok_d = 1'b1;
                        byte_d    = shift_q;
                    end else begin
                        bad_frame_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d     = S_IDLE;
                tcnt_d      = '0;
                timeout_hit = 1'b1;
            end else begin
                tcnt_d = tcnt_q + 1'b1;
            end
        end
        frame_err_d = bad_frame_d | timeout_hit;
    end

    // prefix decoder: tracks E0/F0 flags, swallows the Pause tail, emits completed keys
    always_comb begin
        ext_d     = ext_q;
        brk_d     = brk_q;
        skip_d    = skip_q;
        push      = 1'b0;
        push_data = {ext_q, brk_q, byte_q};
        if (bad_frame_q) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_ok_q) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
            end else begin
                case (byte_q)
                    8'hE1: begin
                        skip_d = 3'd7;
                        ext_d  = 1'b0;
                        brk_d  = 1'b0;
                    end
                    8'hE0: ext_d = 1'b1;
                    8'hF0: brk_d = 1'b1;
                    8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: ;
                    default: begin
                        push  = 1'b1;
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end
                endcase
            end
        end
    end

    // FIFO bookkeeping, registered head entry and sticky overflow flag
    always_comb begin
        full     = (count_q == LW'(FIFO_DEPTH));
        pop      = (count_q != '0) & ev_ready;
        do_push  = push & (~full | pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !pop) count_d = count_q + LW'(1);
        else if (!do_push && pop) count_d = count_q - LW'(1);
        head_d = head_q;
        if (count_d != '0) begin
            head_d = (do_push && (rd_ptr_d == wr_ptr_q)) ? push_data : mem_q[rd_ptr_d];
        end
        overflow_d = overflow_q;
        if (push && full && !pop) overflow_d = 1'b1;
        else if (clr_ovf) overflow_d = 1'b0;
    end

    // register all control state; reset discards any partial frame and pending prefixes
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            tcnt_q      <= '0;
            byte_q      <= '0;
            byte_ok_q   <= 1'b0;
            bad_frame_q <= 1'b0;
            frame_err_q <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            skip_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            head_q      <= '0;
            overflow_q  <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            tcnt_q      <= tcnt_d;
            byte_q      <= byte_d;
            byte_ok_q   <= byte_ok_d;
            bad_frame_q <= bad_frame_d;
            frame_err_q <= frame_err_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            skip_q      <= skip_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            head_q      <= head_d;
            overflow_q  <= overflow_d;
        end
    end

    // FIFO storage; contents only matter once the matching count is non-zero, so no reset
    always_ff @(posedge clk_in) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign ev_valid   = (count_q != '0);
    assign ev_code    = head_q[7:0];
    assign ev_brk     = head_q[8];
    assign ev_ext     = head_q[9];
    assign fifo_level = count_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// tb_ps2_key_event_rx
// Drives PS/2 frames into ps2_key_event_rx. Expected key events are queued as
// frames are sent and are compared when the consumer side accepts them.
module tb_ps2_key_event_rx;

    localparam int SYNC  = 2;
    localparam int TMO   = 200;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk_in;
    logic          rst;
    logic          key_clk;
    logic          key_data;
    logic          ev_valid;
    logic          ev_ready;
    logic [7:0]    ev_code;
    logic          ev_ext;
    logic          ev_brk;
    logic [LW-1:0] fifo_level;
    logic          frame_err;
    logic          overflow;
    logic          clr_ovf;

    int errors = 0;
    int checks = 0;
    logic [9:0] sb [$];
    int err_pulses = 0;
    int err_wide   = 0;
    int max_level  = 0;
    logic err_prev = 1'b0;
    int e0;

    ps2_key_event_rx #(
        .SYNC_STAGES(SYNC),
        .TIMEOUT_CYCLES(TMO),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_in(clk_in),
        .rst(rst),
        .key_clk(key_clk),
        .key_data(key_data),
        .ev_valid(ev_valid),
        .ev_ready(ev_ready),
        .ev_code(ev_code),
        .ev_ext(ev_ext),
        .ev_brk(ev_brk),
        .fifo_level(fifo_level),
        .frame_err(frame_err),
        .overflow(overflow),
        .clr_ovf(clr_ovf)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // consumer-side monitor: pops the scoreboard on each accepted event, tracks frame_err pulses
    always @(negedge clk_in) begin
        if (rst) begin
            if (frame_err) begin
                err_pulses++;
                if (err_prev) err_wide++;
            end
            err_prev = frame_err;
            if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
            if (ev_valid && ev_ready) begin
                checkOutput("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) checkOutput("event", {22'd0, ev_ext, ev_brk, ev_code}, {22'd0, sb.pop_front()});
            end
        end else begin
            err_prev = 1'b0;
        end
    end

    // ev_ready changes away from the sampling edge so monitor and DUT agree on each pop
    task automatic setReady(input logic v);
        @(posedge clk_in);
        #1 ev_ready = v;
    endtask

    // one PS/2 bit: data settles, clock low, clock high; optionally measures event latency
    task automatic ps2Bit(input logic v, input bit measure);
        key_data = v;
        repeat (5) @(negedge clk_in);
        key_clk = 1'b0;
        if (measure) begin
            int n;
            n = 0;
            do begin
                @(posedge clk_in);
                n++;
                @(negedge clk_in);
            end while (!ev_valid && n < 20);
            checkOutput("latency", n, SYNC + 2);
        end
        repeat (10) @(negedge clk_in);
        key_clk = 1'b1;
        repeat (5) @(negedge clk_in);
    endtask

    // one frame (or a truncated frame when nbits < 8), parity optionally corrupted
    task automatic applyStimulus(input logic [7:0] b, input bit flip, input int nbits, input bit measure);
        logic par;
        par = (~^b) ^ flip;
        ps2Bit(1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) ps2Bit(b[i], 1'b0);
        if (nbits == 8) begin
            ps2Bit(par, 1'b0);
            ps2Bit(1'b1, measure);
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        applyStimulus(b, 1'b0, 8, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0; key_clk = 1'b1; key_data = 1'b1; ev_ready = 1'b1; clr_ovf = 1'b0;
        repeat (3) @(negedge clk_in);
        checkOutput("rst_ev_valid", ev_valid, 0);
        checkOutput("rst_ev_word", {ev_ext, ev_brk, ev_code}, 0);
        checkOutput("rst_level", fifo_level, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_frame_err", frame_err, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk_in);

        // plain make code with latency measurement
        sb.push_back({2'b00, 8'h1C});
        applyStimulus(8'h1C, 1'b0, 8, 1'b1);
        repeat (5) @(negedge clk_in);
        checkOutput("t1_sb_empty", sb.size(), 0);

        // extended release collapses into one event
        max_level = 0;
        sb.push_back({2'b11, 8'h75});
        sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h75);
        repeat (5) @(negedge clk_in);
        checkOutput("t2_sb_empty", sb.size(), 0);
        checkOutput("t2_max_level", max_level, 1);

        // parity error clears pending break flag
        e0 = err_pulses;
        sendByte(8'hF0);
        applyStimulus(8'h1C, 1'b1, 8, 1'b0);
        repeat (5) @(negedge clk_in);
        checkOutput("t3_err_pulse", err_pulses, e0 + 1);
        sb.push_back({2'b00, 8'h1C});
        sendByte(8'h1C);
        repeat (5) @(negedge clk_in);
        checkOutput("t3_sb_empty", sb.size(), 0);

        // truncated frame times out, then receiver recovers
        e0 = err_pulses;
        applyStimulus(8'h55, 1'b0, 5, 1'b0);
        repeat (TMO + 10) @(negedge clk_in);
        checkOutput("t4_timeout_err", err_pulses, e0 + 1);
        sb.push_back({2'b00, 8'h29});
        sendByte(8'h29);
        sendByte(8'hFA);
        repeat (5) @(negedge clk_in);
        checkOutput("t4_sb_empty", sb.size(), 0);
        checkOutput("t4_no_extra_err", err_pulses, e0 + 1);

        // overflow: nine makes into an eight-entry FIFO with no consumer
        setReady(1'b0);
        for (int i = 0; i <= DEPTH; i++) begin
            if (i < DEPTH) sb.push_back({2'b00, 8'(8'h15 + i)});
            sendByte(8'(8'h15 + i));
            if (i == 1) checkOutput("t5_head_hold", ev_code, 8'h15);
        end
        repeat (5) @(negedge clk_in);
        checkOutput("t5_level_full", fifo_level, DEPTH);
        checkOutput("t5_overflow", overflow, 1);
        checkOutput("t5_head_stable", ev_code, 8'h15);
        setReady(1'b1);
        for (int k = 0; k < 40 && ev_valid; k++) @(negedge clk_in);
        checkOutput("t5_drained_valid", ev_valid, 0);
        checkOutput("t5_drained_level", fifo_level, 0);
        checkOutput("t5_sb_empty", sb.size(), 0);
        checkOutput("t5_last_hold", ev_code, 8'h1C);
        checkOutput("t5_ovf_sticky", overflow, 1);
        clr_ovf = 1'b1;
        @(negedge clk_in);
        clr_ovf = 1'b0;
        @(negedge clk_in);
        checkOutput("t5_ovf_cleared", overflow, 0);

        // Pause sequence is swallowed entirely
        sb.push_back({2'b00, 8'h1C});
        sendByte(8'hE1); sendByte(8'h14); sendByte(8'h77); sendByte(8'hE1);
        sendByte(8'hF0); sendByte(8'h14); sendByte(8'hF0); sendByte(8'h77);
        sendByte(8'h1C);
        repeat (5) @(negedge clk_in);
        checkOutput("t6_sb_empty", sb.size(), 0);

        // reset while an event is queued and a frame is in flight
        setReady(1'b0);
        sendByte(8'h2A);
        repeat (5) @(negedge clk_in);
        checkOutput("t6_queued", ev_valid, 1);
        applyStimulus(8'h33, 1'b0, 4, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk_in);
        checkOutput("t6_rst_valid", ev_valid, 0);
        checkOutput("t6_rst_word", {ev_ext, ev_brk, ev_code}, 0);
        checkOutput("t6_rst_level", fifo_level, 0);
        checkOutput("t6_rst_overflow", overflow, 0);
        checkOutput("t6_rst_frame_err", frame_err, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk_in);
        setReady(1'b1);
        sb.push_back({2'b00, 8'h1C});
        sendByte(8'h1C);
        repeat (5) @(negedge clk_in);

        checkOutput("final_sb_empty", sb.size(), 0);
        checkOutput("err_pulse_width", err_wide, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
